// File: rtl/ram_burst_ctrl.sv
// ram_burst_ctrl -- burst access controller in front of a single-port RAM.
//
// Takes one burst command at a time and runs it against the RAM at one beat
// per cycle. Write beats pass straight through to the RAM pins. Read beats
// come back one cycle later from the RAM's registered output and land in a
// 2-entry in-order buffer that absorbs consumer backpressure.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   cmd_valid/cmd_ready        command handshake (ready only in IDLE)
//   cmd_wr, cmd_addr, cmd_len  direction, start address, beats minus one
//   wdata_valid/ready, wdata   write beat channel (ready only in WRITE)
//   rdata_valid/ready, rdata   read beat channel (head of output buffer)
//   busy                       FSM not in IDLE
//   err                        one-cycle pulse on a rejected wrapping command
//   ram_cs/rd/wr, ram_addr     RAM controls
//   ram_data, ram_dout         RAM write data / registered read data
//
// Build option
//   RAM_BURST_WRAP_ERR_EN  when defined, a command whose burst would run past
//                          the top address is accepted but dropped and err
//                          pulses; otherwise bursts wrap to address 0 and err
//                          is tied low.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for a command, cmd_ready high
// S_WRITE | one RAM write per accepted write beat
// S_READ  | issuing RAM reads while the buffer has room
// S_DRAIN | all reads issued, waiting for buffer and pipeline to empty

module ram_burst_ctrl #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8,
  parameter int LEN_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_wr,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic              wdata_valid,
  output logic              wdata_ready,
  input  logic [DATA_W-1:0] wdata,
  output logic              rdata_valid,
  input  logic              rdata_ready,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic              err,
  output logic              ram_cs,
  output logic              ram_rd,
  output logic              ram_wr,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_data,
  input  logic [DATA_W-1:0] ram_dout
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WRITE = 2'd1;
  localparam logic [1:0] S_READ  = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
  localparam logic [LEN_W-1:0]  LEN_ONE  = LEN_W'(1);

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic              inflight_q, inflight_d;
  logic [1:0]        occ_q, occ_d;
  logic [DATA_W-1:0] buf0_q, buf0_d;
  logic [DATA_W-1:0] buf1_q, buf1_d;

  logic cmd_ok;
  logic wr_fire;
  logic rd_issue;
  logic push;
  logic pop;

`ifdef RAM_BURST_WRAP_ERR_EN
  localparam int SUM_W = ((ADDR_W > LEN_W) ? ADDR_W : LEN_W) + 1;
  localparam logic [SUM_W-1:0] ADDR_MAX = {{(SUM_W-ADDR_W){1'b0}}, {ADDR_W{1'b1}}};

  logic err_q, err_d;

  assign cmd_ok = (SUM_W'(cmd_addr) + SUM_W'(cmd_len)) <= ADDR_MAX;
  assign err    = err_q;
`else
  assign cmd_ok = 1'b1;
  assign err    = 1'b0;
`endif

  assign push = inflight_q;
  assign pop  = rdata_valid && rdata_ready;

  // A read may only be issued if its data is guaranteed a buffer slot when
  // it returns next cycle, counting the beat already in flight and the beat
  // leaving this cycle.
  assign wr_fire  = (state_q == S_WRITE) && wdata_valid;
  assign rd_issue = (state_q == S_READ) &&
                    (({1'b0, occ_q} + {2'b00, inflight_q}) < (3'd2 + {2'b00, pop}));

  assign cmd_ready   = rst_n && (state_q == S_IDLE);
  assign wdata_ready = (state_q == S_WRITE);
  assign busy        = (state_q != S_IDLE);
  assign ram_wr      = wr_fire;
  assign ram_rd      = rd_issue;
  assign ram_cs      = wr_fire || rd_issue;
  assign ram_addr    = ram_cs ? addr_q : '0;
  assign ram_data    = wr_fire ? wdata : '0;
  assign rdata_valid = (occ_q != 2'd0);
  assign rdata       = buf0_q;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    cnt_d      = cnt_q;
    inflight_d = 1'b0;
`ifdef RAM_BURST_WRAP_ERR_EN
    err_d      = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          if (cmd_ok) begin
            addr_d  = cmd_addr;
            cnt_d   = cmd_len;
            state_d = cmd_wr ? S_WRITE : S_READ;
          end
`ifdef RAM_BURST_WRAP_ERR_EN
          else begin
            err_d = 1'b1;
          end
`endif
        end
      end
      S_WRITE: begin
        if (wr_fire) begin
          addr_d = addr_q + ADDR_ONE;
          cnt_d  = cnt_q - LEN_ONE;
          if (cnt_q == '0) state_d = S_IDLE;
        end
      end
      S_READ: begin
        if (rd_issue) begin
          addr_d     = addr_q + ADDR_ONE;
          cnt_d      = cnt_q - LEN_ONE;
          inflight_d = 1'b1;
          if (cnt_q == '0) state_d = S_DRAIN;
        end
      end
      default: begin
        if ((occ_q == 2'd0) && !inflight_q) state_d = S_IDLE;
      end
    endcase
  end

  // Output buffer: buf0 is always the head, buf1 the second entry.
  always_comb begin
    buf0_d = buf0_q;
    buf1_d = buf1_q;
    occ_d  = occ_q;
    case ({push, pop})
      2'b10: begin
        if (occ_q == 2'd0) buf0_d = ram_dout;
        else               buf1_d = ram_dout;
        occ_d = occ_q + 2'd1;
      end
      2'b01: begin
        buf0_d = buf1_q;
        occ_d  = occ_q - 2'd1;
      end
      2'b11: begin
        if (occ_q == 2'd1) begin
          buf0_d = ram_dout;
        end else begin
          buf0_d = buf1_q;
          buf1_d = ram_dout;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      cnt_q      <= '0;
      inflight_q <= 1'b0;
      occ_q      <= 2'd0;
      buf0_q     <= '0;
      buf1_q     <= '0;
`ifdef RAM_BURST_WRAP_ERR_EN
      err_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      cnt_q      <= cnt_d;
      inflight_q <= inflight_d;
      occ_q      <= occ_d;
      buf0_q     <= buf0_d;
      buf1_q     <= buf1_d;
`ifdef RAM_BURST_WRAP_ERR_EN
      err_q      <= err_d;
`endif
    end
  end

endmodule

// File: tb/tb_ram_burst_ctrl.sv
// Testbench for ram_burst_ctrl. A behavioural RAM answers the controller's
// pins; a separate reference memory image is updated per burst command with
// modular address arithmetic and used to predict every read beat.

module tb_ram_burst_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid, cmd_wr;
  logic [9:0] cmd_addr;
  logic [7:0] cmd_len;
  logic       cmd_ready;
  logic       wdata_valid, wdata_ready;
  logic [7:0] wdata;
  logic       rdata_valid, rdata_ready;
  logic [7:0] rdata;
  logic       busy, err;
  logic       ram_cs, ram_rd, ram_wr;
  logic [9:0] ram_addr;
  logic [7:0] ram_data;
  logic [7:0] ram_dout = 8'h00;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] ref_mem [0:1023];

  ram_burst_ctrl #(.ADDR_W(10), .DATA_W(8), .LEN_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata),
    .rdata_valid(rdata_valid), .rdata_ready(rdata_ready), .rdata(rdata),
    .busy(busy), .err(err),
    .ram_cs(ram_cs), .ram_rd(ram_rd), .ram_wr(ram_wr),
    .ram_addr(ram_addr), .ram_data(ram_data), .ram_dout(ram_dout)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [7:0] init_val(input int a);
    return 8'(a * 37 + 11);
  endfunction

  // Behavioural RAM with a one-cycle registered read.
  logic [7:0] ram_mem [0:1023];
  logic       ram_init = 1'b0;
  logic       req_wr = 1'b0, req_rd = 1'b0;
  logic [9:0] req_addr = 10'h0;
  logic [7:0] req_data = 8'h0;

  always @(negedge clk) begin
    req_wr   = ram_cs && ram_wr;
    req_rd   = ram_cs && ram_rd;
    req_addr = ram_addr;
    req_data = ram_data;
  end

  always @(posedge clk) begin
    if (!ram_init) begin
      for (int i = 0; i < 1024; i++) ram_mem[10'(i)] = init_val(i);
      ram_init = 1'b1;
    end
    if (req_wr) ram_mem[req_addr] = req_data;
    if (req_rd) ram_dout <= ram_mem[req_addr];
  end

  // Cycle-level invariants: pin exclusivity, read-ahead bound, stall stability.
  int         iss = 0, pops = 0;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data = 8'h0;

  always @(negedge clk) begin
    if (!rst_n) begin
      iss = 0;
      pops = 0;
      prev_stall = 1'b0;
    end else begin
      check_eq("rd_wr_excl", 32'(ram_rd && ram_wr), 0);
      check_eq("cs_match", 32'(ram_cs), 32'(ram_rd || ram_wr));
      if (ram_rd) iss++;
      if (rdata_valid && rdata_ready) pops++;
      if (ram_rd) check_eq("buf_bound", 32'((iss - pops) <= 2), 1);
      if (prev_stall) begin
        check_eq("stall_valid", 32'(rdata_valid), 1);
        check_eq("stall_data", 32'(rdata), 32'(prev_data));
      end
      prev_stall = rdata_valid && !rdata_ready;
      prev_data  = rdata;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic send_cmd(input bit wr, input int addr, input int len);
    @(posedge clk); #2;
    cmd_valid = 1'b1;
    cmd_wr    = wr;
    cmd_addr  = 10'(addr);
    cmd_len   = 8'(len);
    @(negedge clk);
    check_eq("cmd_ready", 32'(cmd_ready), 1);
    @(posedge clk); #2;
    cmd_valid = 1'b0;
    cmd_wr    = 1'($urandom);
    cmd_addr  = 10'($urandom);
    cmd_len   = 8'($urandom);
  endtask

`ifdef RAM_BURST_WRAP_ERR_EN
  task automatic err_path();
    @(negedge clk);
    check_eq("err_pulse", 32'(err), 1);
    check_eq("err_busy", 32'(busy), 0);
    check_eq("err_no_cs", 32'(ram_cs), 0);
    @(posedge clk); #2;
    @(negedge clk);
    check_eq("err_clear", 32'(err), 0);
    check_eq("err_idle", 32'(cmd_ready), 1);
  endtask
`endif

  task automatic wr_burst(input int addr, input int len, input int base, input bit hold);
    int i = 0;
    int k = 1;
    int first = -1;
    int last = -1;
    logic [7:0] dat [$];
    logic [9:0] a;
    for (int j = 0; j <= len; j++) dat.push_back(base >= 0 ? 8'(base + j) : 8'($urandom));
    send_cmd(1'b1, addr, len);
`ifdef RAM_BURST_WRAP_ERR_EN
    if (addr + len > 1023) begin
      err_path();
      return;
    end
`endif
    while (i <= len && k < 8 * (len + 1) + 40) begin
      wdata_valid = hold || ($urandom_range(0, 3) != 0);
      wdata = dat[i];
      @(negedge clk);
      if (wdata_valid) begin
        a = 10'(addr + i);
        check_eq("wr_ready", 32'(wdata_ready), 1);
        check_eq("wr_strobe", 32'({ram_cs, ram_wr, ram_rd}), 32'h6);
        check_eq("wr_addr", 32'(ram_addr), 32'(a));
        check_eq("wr_data", 32'(ram_data), 32'(dat[i]));
        ref_mem[a] = dat[i];
        if (first < 0) first = k;
        last = k;
        i++;
      end else begin
        check_eq("wr_gap_cs", 32'(ram_cs), 0);
      end
      @(posedge clk); #2;
      k++;
    end
    wdata_valid = 1'b0;
    check_eq("wr_beats", i, len + 1);
    @(negedge clk);
    check_eq("wr_end_ready", 32'(cmd_ready), 1);
    check_eq("wr_end_busy", 32'(busy), 0);
    if (hold) begin
      check_eq("wr_first_cyc", first, 1);
      check_eq("wr_last_cyc", last, 1 + len);
    end
  endtask

  // mode 0: always ready, 1: ready pattern 1,0,0,1 repeating, 2: random ready
  task automatic rd_burst(input int addr, input int len, input int mode);
    int got = 0;
    int k = 1;
    int first = -1;
    int last = -1;
    bit done = 1'b0;
    logic [7:0] exp_q [$];
    logic [9:0] a;
    for (int j = 0; j <= len; j++) begin
      a = 10'(addr + j);
      exp_q.push_back(ref_mem[a]);
    end
    send_cmd(1'b0, addr, len);
`ifdef RAM_BURST_WRAP_ERR_EN
    if (addr + len > 1023) begin
      err_path();
      return;
    end
`endif
    while (!done && k < 8 * (len + 1) + 40) begin
      case (mode)
        0:       rdata_ready = 1'b1;
        1:       rdata_ready = (((k - 1) % 4) == 0) || (((k - 1) % 4) == 3);
        default: rdata_ready = 1'($urandom);
      endcase
      @(negedge clk);
      if (rdata_valid && rdata_ready) begin
        if (exp_q.size() == 0) begin
          check_eq("rd_extra", got + 1, len + 1);
        end else begin
          check_eq("rdata", 32'(rdata), 32'(exp_q.pop_front()));
          if (first < 0) first = k;
          last = k;
        end
        got++;
      end
      if (cmd_ready) done = 1'b1;
      else begin
        @(posedge clk); #2;
        k++;
      end
    end
    rdata_ready = 1'b0;
    check_eq("rd_done", 32'(done), 1);
    check_eq("rd_count", got, len + 1);
    if (mode == 0) begin
      check_eq("rd_first_cyc", first, 3);
      check_eq("rd_last_cyc", last, 3 + len);
    end
  endtask

  initial begin
    int a, l;
    rst_n       = 1'b1;
    cmd_valid   = 1'b0;
    cmd_wr      = 1'b0;
    cmd_addr    = 10'h0;
    cmd_len     = 8'h0;
    wdata_valid = 1'b0;
    wdata       = 8'h0;
    rdata_ready = 1'b0;
    for (int i = 0; i < 1024; i++) ref_mem[10'(i)] = init_val(i);
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_cmd_ready", 32'(cmd_ready), 0);
    check_eq("rst_ctrl_outs", 32'({busy, err, rdata_valid, wdata_ready, ram_cs, ram_rd, ram_wr}), 0);
    check_eq("rst_bus_outs", 32'({ram_addr, ram_data}), 0);
    check_eq("rst_rdata", 32'(rdata), 0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("idle_cmd_ready", 32'(cmd_ready), 1);
    check_eq("idle_busy", 32'(busy), 0);

    wr_burst(10'h010, 3, 8'hA0, 1'b1);
    rd_burst(10'h010, 3, 0);
    rd_burst(10'h010, 7, 1);
    wr_burst(10'h3FE, 3, 8'hB0, 1'b1);
    rd_burst(10'h3FE, 3, 0);
    rd_burst(10'h3FC, 3, 0);
    rd_burst(10'h3FF, 0, 1);
    wr_burst(10'h100, 40, -1, 1'b0);
    rd_burst(10'h0F0, 255, 2);

    for (int t = 0; t < 20; t++) begin
      a = $urandom_range(0, 1023);
      l = $urandom_range(0, 12);
      wr_burst(a, l, -1, 1'($urandom));
      rd_burst(a, l, $urandom_range(0, 2));
      rd_burst($urandom_range(0, 1023), $urandom_range(0, 12), $urandom_range(0, 2));
    end

    // Reset in the middle of a long read burst.
    send_cmd(1'b0, 200, 15);
    rdata_ready = 1'b1;
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_ctrl", 32'({cmd_ready, busy, err, rdata_valid, wdata_ready, ram_cs, ram_rd, ram_wr}), 0);
    check_eq("mid_rst_bus", 32'({ram_addr, ram_data}), 0);
    check_eq("mid_rst_rdata", 32'(rdata), 0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    rdata_ready = 1'b0;
    @(negedge clk);
    check_eq("post_rst_ready", 32'(cmd_ready), 1);
    check_eq("post_rst_rvalid", 32'(rdata_valid), 0);
    check_eq("post_rst_busy", 32'(busy), 0);
    wr_burst(300, 5, -1, 1'b1);
    rd_burst(300, 5, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ram_burst_ctrl.md
# ram_burst_ctrl

Burst access controller that sits directly upstream of the single-port RAM and is its only master. It accepts one burst command at a time over a valid/ready handshake. It then drives the RAM's cs/rd/wr/addr/data pins for one beat per cycle, streaming write data in and read data out over valid/ready channels. It absorbs the RAM's one-cycle registered read latency and tolerates consumer backpressure with a 2-entry output buffer.

## Interface
- ADDR_W, 10, RAM address width
- DATA_W, 8, data width
- LEN_W, 8, burst length field width; a burst is cmd_len+1 beats (1..2^LEN_W)

Ports:
- clk  in  1  clock; all logic on posedge
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  high only in IDLE
- cmd_wr  in  1  1 = write burst, 0 = read burst
- cmd_addr  in  ADDR_W  start address
- cmd_len  in  LEN_W  beats minus one
- wdata_valid  in  1  write beat offered
- wdata_ready  out  1  high only in WRITE
- wdata  in  DATA_W  write beat
- rdata_valid  out  1  read beat available
- rdata_ready  in  1  consumer accepts read beat
- rdata  out  DATA_W  read beat
- busy  out  1  state != IDLE
- err  out  1  one-cycle pulse (only with macro, see Configuration)
- ram_cs, ram_rd, ram_wr  out  1 each  RAM controls
- ram_addr  out  ADDR_W  RAM address
- ram_data  out  DATA_W  RAM write data
- ram_dout  in  DATA_W  RAM registered read data

## Operation
- FSM states: IDLE, WRITE, READ, DRAIN. Reset → IDLE.
- IDLE: cmd_ready=1. A handshake latches addr, the beat counter (cmd_len) and direction. Next state is WRITE or READ.
- WRITE:
  - ram_cs=ram_wr=wdata_valid; ram_data=wdata and ram_addr=current address, both combinational.
  - Each handshake increments the address and decrements the counter.
  - The last beat returns to IDLE at the same edge.
- READ:
  - A read is issued (ram_cs=ram_rd=1) when occupancy + inflight − pop < 2, where pop = rdata_valid&&rdata_ready.
  - Each issue advances the address and counter; the inflight flag is set.
  - The cycle after an issue, ram_dout is pushed into the buffer.
  - After the last issue the FSM moves to DRAIN.
- DRAIN: no RAM access. Moves to IDLE when the buffer is empty and nothing is inflight.
- Buffer: 2-entry FIFO, in-order. rdata_valid = buffer non-empty; rdata = head. Simultaneous push and pop is allowed.
- ram_rd and ram_wr are never both high. ram_cs=0 whenever neither is high.
- Address arithmetic is modulo 2^ADDR_W: 1023+1 → 0 for the default width.
- Reset mid-burst:
  - All state, the buffer, the inflight flag and the counters clear asynchronously.
  - The burst is abandoned; RAM contents written so far remain.
- Outputs on reset: cmd_ready=0 while rst_n is low, 1 once in IDLE. All other outputs are 0.

## Timing
- Cycle 0 = command handshake cycle. First RAM access is at cycle 1 at the earliest.
- Write: one beat per cycle when wdata_valid stays high. cmd_ready returns the cycle after the last beat.
- Read: ram_rd in cycle n → data pushed at end of cycle n+1 → rdata_valid in cycle n+2.
  - First rdata_valid is at cycle 3.
  - Throughput is 1 beat/cycle while rdata_ready=1.
- The rdata_ready=0 stall takes effect at most after 2 buffered beats. No beat is lost or duplicated.
- rdata/rdata_valid stay stable while rdata_valid && !rdata_ready.

## Configuration
- Macro RAM_BURST_WRAP_ERR_EN.
- Defined:
  - A command with cmd_addr + cmd_len > 2^ADDR_W−1 is accepted but not executed.
  - err pulses high for the cycle after the handshake, the FSM stays in IDLE, and there is no RAM access.
- Undefined:
  - err is tied to 0.
  - Bursts wrap to address 0.

## Test plan
- Write burst addr=0x010, len=3, data A0..A3 with wdata_valid held → ram_wr in cycles 1–4 at addr 0x010..0x013; cmd_ready=1 in cycle 5.
- Read back the same range with rdata_ready=1 → rdata A0,A1,A2,A3 in cycles 3–6; ram_rd/ram_wr are never both high.
- Read len=7 with rdata_ready toggling 1,0,0,1,… → all 8 beats delivered in order with no duplicates; the buffer never exceeds 2 entries.
- Write addr=0x3FE, len=3 → macro off: writes to 0x3FE,0x3FF,0x000,0x001. Macro on: err pulses in cycle 1, no ram_cs, busy=0.
- rst_n low during cycle 2 of a len=15 read → all outputs 0 immediately; after release cmd_ready=1, rdata_valid=0; a new write command works normally.
